// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for RV32I R/I-type ALU ops.
// Optional retired-instruction counter is built only when CTRL_PERF_CNT_EN is defined.
module rv32i_multicycle_ctrl #(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_rdata,
  output logic [3:0]  alu_control_en,
  output logic        imm_en,
  output logic        register_write_en,
  output logic        pc_en,
  output logic        illegal_instr,
  output logic        busy,
  output logic [31:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0]  HOLD_INIT = 4'(RESET_PC_HOLD);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  alu_q, alu_d;
  logic        imm_q, imm_d;
  logic [3:0]  hold_q, hold_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, is_i, legal;
  logic [3:0] alu_dec;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = (funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_i) begin
      case (funct3)
        3'b001:  legal = (funct7 == 7'b0000000);
        3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        default: legal = 1'b1;
      endcase
    end
  end

  // Immediate shifts carry the arithmetic bit in funct7; other I-type ops ignore it.
  assign alu_dec = {(is_r || (funct3 == 3'b101)) ? funct7[5] : 1'b0, funct3};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= NOP;
      alu_q   <= 4'b0000;
      imm_q   <= 1'b0;
      hold_q  <= HOLD_INIT;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    imm_d   = imm_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
        else if (run)       state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          alu_d   = alu_dec;
          imm_d   = is_i;
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Strobes decode from registered state/IR only, so imem_* never reaches an output.
  assign imem_req          = (state_q == S_FETCH);
  assign pc_en             = (state_q == S_WRITEBACK);
  assign register_write_en = (state_q == S_WRITEBACK) && (ir_q[11:7] != 5'd0);
  assign illegal_instr     = (state_q == S_HALT);
  assign busy              = (state_q != S_IDLE) && (state_q != S_HALT);
  assign Instr_rdata       = ir_q;
  assign alu_control_en    = alu_q;
  assign imm_en            = imm_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt_q <= 32'd0;
    else if (state_q == S_WRITEBACK) cnt_q <= cnt_q + 32'd1;
  end
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Randomized + directed bench for rv32i_multicycle_ctrl with an instruction-level reference model.
module tb_rv32i_multicycle_ctrl;
  localparam int HOLD = 2;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] Instr_rdata;
  logic [3:0]  alu_control_en;
  logic        imm_en, register_write_en, pc_en, illegal_instr, busy;
  logic [31:0] retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  rv32i_multicycle_ctrl #(.RESET_PC_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instr_rdata(Instr_rdata), .alu_control_en(alu_control_en), .imm_en(imm_en),
    .register_write_en(register_write_en), .pc_en(pc_en),
    .illegal_instr(illegal_instr), .busy(busy), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-level) ----------------
  function automatic bit ref_legal(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    if (i[6:0] == 7'h33)
      return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (i[6:0] == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] i);
    int v;
    v = int'(i[14:12]);
    if (i[30] && (i[6:0] == 7'h33 || i[14:12] == 3'd5)) v = v + 8;
    return 4'(v);
  endfunction

  // m_age counts cycles since the instruction word was accepted (1=decode,2=execute,3=writeback)
  bit          m_fetch, m_halt, m_imm;
  int          m_age, m_hold;
  logic [31:0] m_ir, m_cnt;
  logic [3:0]  m_alu;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fetch <= 0; m_halt <= 0; m_age <= 0; m_hold <= HOLD;
      m_ir <= 32'h13; m_alu <= 0; m_imm <= 0; m_cnt <= 0;
    end else if (m_halt) begin
      m_halt <= 1;
    end else if (m_fetch) begin
      if (imem_ready) begin m_ir <= imem_rdata; m_fetch <= 0; m_age <= 1; end
    end else if (m_age == 1) begin
      if (ref_legal(m_ir)) begin
        m_alu <= ref_alu(m_ir); m_imm <= (m_ir[6:0] == 7'h13); m_age <= 2;
      end else begin
        m_halt <= 1; m_age <= 0;
      end
    end else if (m_age == 2) begin
      m_age <= 3;
    end else if (m_age == 3) begin
      m_age <= 0; m_cnt <= m_cnt + 1; m_fetch <= run;
    end else if (m_hold > 0) begin
      m_hold <= m_hold - 1;
    end else if (run) begin
      m_fetch <= 1;
    end
  end

  always @(posedge clk) begin
    #3;
    if (cmp_en) begin
      logic [9:0] e, a;
      e = {m_fetch, (m_fetch || m_age != 0), m_halt, (m_age == 3),
           (m_age == 3 && m_ir[11:7] != 0), m_imm, m_alu};
      a = {imem_req, busy, illegal_instr, pc_en, register_write_en, imm_en, alu_control_en};
      chk("model_ctrl{req,busy,ill,pc,wen,imm,alu}", 32'(a), 32'(e));
      chk("model_ir", Instr_rdata, m_ir);
      chk("model_retired", retired_cnt, PERF ? m_cnt : 32'd0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic first_req_after_release();
    int n = 0;
    @(negedge clk); reset = 1'b0; run = 1'b1;
    do begin tick(); n++; end while (!imem_req && n < 40);
    chk("first_req_cycle", n, HOLD + 1);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int waits, input logic [3:0] ealu,
                           input bit eimm, input bit ewen, input bit elegal);
    int n, guard;
    logic [31:0] c0;
    imem_rdata = ins; imem_ready = 1'b0;
    guard = 0;
    while (!imem_req && guard < 40) begin tick(); guard++; end
    chk("req_seen", 32'(imem_req), 1);
    n = 1;
    imem_ready = (waits == 0);
    guard = 0;
    forever begin
      tick(); guard++;
      if (!imem_req || guard > 40) break;
      n++;
      if (n > waits) imem_ready = 1'b1;
    end
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("fetch_cycles", n, waits + 1);
    chk("ir_latched", Instr_rdata, ins);
    chk("decode_no_pc", 32'(pc_en), 0);
    c0 = retired_cnt;
    tick();
    if (!elegal) begin
      for (int k = 0; k < 5; k++) begin
        chk("halt_flags{ill,req,busy,pc,wen}",
            32'({illegal_instr, imem_req, busy, pc_en, register_write_en}), 32'b10000);
        tick();
      end
      return;
    end
    chk("exec_alu", 32'(alu_control_en), 32'(ealu));
    chk("exec_imm", 32'(imm_en), 32'(eimm));
    chk("exec_no_pc", 32'(pc_en), 0);
    tick();
    chk("wb_pc", 32'(pc_en), 1);
    chk("wb_wen", 32'(register_write_en), 32'(ewen));
    chk("wb_alu", 32'(alu_control_en), 32'(ealu));
    tick();
    chk("after_wb_pulses", 32'({pc_en, register_write_en}), 0);
    chk("retired_step", retired_cnt, PERF ? c0 + 1 : 32'd0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    if (sel <= 3) return {f7, r[24:7], 7'h33};
    if (sel <= 7) return {f7, r[24:7], 7'h13};
    if (sel == 8) return r;
    return 32'h13;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    tick(); cmp_en = 1'b1; tick();
    chk("rst_ctrl{req,busy,ill,pc,wen,imm,alu}",
        32'({imem_req, busy, illegal_instr, pc_en, register_write_en, imm_en, alu_control_en}), 0);
    chk("rst_ir", Instr_rdata, 32'h0000_0013);
    chk("rst_retired", retired_cnt, 0);

    first_req_after_release();
    run_instr(32'h002081B3, 0, 4'b0000, 1'b0, 1'b1, 1'b1); // ADD x3,x1,x2
    run_instr(32'h402081B3, 0, 4'b1000, 1'b0, 1'b1, 1'b1); // SUB
    run_instr(32'h40335293, 1, 4'b1101, 1'b1, 1'b1, 1'b1); // SRAI x5,x6,3
    run_instr(32'h00100013, 3, 4'b0000, 1'b1, 1'b0, 1'b1); // ADDI x0,x0,1
    run_instr(32'h00000000, 0, 4'b0000, 1'b0, 1'b0, 1'b0); // illegal -> HALT
    chk("halt_sticky", 32'(illegal_instr), 1);

    // reset while in EXECUTE
    @(negedge clk); reset = 1'b1; @(negedge clk);
    first_req_after_release();
    imem_rdata = 32'h402081B3; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0;
    tick();
    chk("pre_rst_exec_alu", 32'(alu_control_en), 32'h8);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_ctrl",
        32'({imem_req, busy, illegal_instr, pc_en, register_write_en, imm_en, alu_control_en}), 0);
    chk("async_rst_ir", Instr_rdata, 32'h13);
    chk("async_rst_retired", retired_cnt, 0);
    first_req_after_release();

    // run dropped mid-instruction: finish, then stay idle
    imem_rdata = 32'h00A00093; imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; run = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      chk("idle_after_run_drop{req,busy}", 32'({imem_req, busy}), 0);
      tick();
    end

    // randomized phase
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      run        = ($urandom_range(0, 7) != 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      imem_rdata = gen_instr();
      reset      = (illegal_instr && $urandom_range(0, 3) == 0) || ($urandom_range(0, 200) == 0);
    end
    @(negedge clk); reset = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
